// File: rtl/picomips_ctrl_pkg.sv
// Shared types and constants for the picoMIPS I/O handshake controller.
package picomips_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    ACK
  } ctrl_state_t;

  // Switch index used as the operator handshake, and width of the data byte.
  localparam int HS_BIT = 8;
  localparam int DATA_W = 8;

endpackage

// File: rtl/sw_debounce.sv
// Debounce counter for one already-synchronised switch bit.
// q follows d only after d has differed from q for DEBOUNCE_CYCLES
// consecutive clock samples; any agreeing sample restarts the count.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic nReset,
  input  logic d,
  output logic q
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;

  // Count consecutive disagreeing samples; flip the output on the last one.
  always_comb begin
    cnt_d = '0;
    q_d   = q_q;
    if (d != q_q) begin
      if (cnt_q == CNT_LAST) begin
        q_d = d;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/picomips_io_handshake_ctrl.sv
// picoMIPS sequencing controller: generates the CPU clock enable from a
// free-running divider and stalls the CPU during input instructions until
// the operator presses and releases SW[8], delivering SW[7:0] with a
// one-cycle acknowledge.
// Optional build macro PICOMIPS_HALT_SWITCH_EN: SW[9]=1 suppresses the
// free-run cpu_en pulses in IDLE (the handshake ACK still fires).
module picomips_io_handshake_ctrl
  import picomips_ctrl_pkg::*;
#(
  parameter int DIV             = 5000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [9:0]        sw_raw,
  input  logic              cpu_req,
  output logic              cpu_en,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_data,
  output logic              waiting
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [9:0]        sw_meta_q, sw_meta_d;
  logic [9:0]        sws_q, sws_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  ctrl_state_t       state_q, state_d;
  logic              cpu_en_q, cpu_en_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              waiting_q, waiting_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic              db;
  logic              tick;
  logic              halt;

  // Two-flop synchroniser for every switch.
  always_comb begin
    sw_meta_d = sw_raw;
    sws_d     = sw_meta_q;
  end

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hs_debounce (
    .clk   (clk),
    .nReset(nReset),
    .d     (sws_q[HS_BIT]),
    .q     (db)
  );

`ifdef PICOMIPS_HALT_SWITCH_EN
  assign halt = sws_q[9];
`else
  logic sw9_unused;
  assign sw9_unused = sws_q[9];
  assign halt       = 1'b0;
`endif

  // Free-running divider; keeps counting through stalls so the tick phase
  // is never disturbed by a handshake.
  assign tick = (div_cnt_q == DIV_LAST);
  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  // Next-state logic and registered decode of the next state for outputs.
  always_comb begin
    state_d    = state_q;
    cpu_data_d = cpu_data_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) state_d = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!cpu_req) begin
          state_d = IDLE;
        end else if (db) begin
          cpu_data_d = sws_q[DATA_W-1:0];
          state_d    = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!cpu_req) begin
          state_d = IDLE;
        end else if (!db) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    waiting_d = (state_d == WAIT_PRESS) || (state_d == WAIT_RELEASE);
    cpu_ack_d = (state_d == ACK);
    cpu_en_d  = (state_d == ACK) || ((state_d == IDLE) && tick && !halt);
  end

  // All state and output registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sw_meta_q  <= '0;
      sws_q      <= '0;
      div_cnt_q  <= '0;
      state_q    <= IDLE;
      cpu_en_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      waiting_q  <= 1'b0;
      cpu_data_q <= '0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sws_q      <= sws_d;
      div_cnt_q  <= div_cnt_d;
      state_q    <= state_d;
      cpu_en_q   <= cpu_en_d;
      cpu_ack_q  <= cpu_ack_d;
      waiting_q  <= waiting_d;
      cpu_data_q <= cpu_data_d;
    end
  end

  assign cpu_en   = cpu_en_q;
  assign cpu_ack  = cpu_ack_q;
  assign waiting  = waiting_q;
  assign cpu_data = cpu_data_q;

endmodule

// File: tb/tb_picomips_io_handshake_ctrl.sv
// Self-checking bench for picomips_io_handshake_ctrl (DIV=4, DEBOUNCE_CYCLES=3).
// Define PICOMIPS_HALT_SWITCH_EN for both bench and RTL to exercise SW[9].
module tb_picomips_io_handshake_ctrl;

  localparam int DIV = 4;
  localparam int DBC = 3;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic [9:0] sw_raw = '0;
  logic       cpu_req = 1'b0;
  logic       cpu_en, cpu_ack, waiting;
  logic [7:0] cpu_data;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  picomips_io_handshake_ctrl #(
    .DIV(DIV),
    .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk     (clk),
    .nReset  (nReset),
    .sw_raw  (sw_raw),
    .cpu_req (cpu_req),
    .cpu_en  (cpu_en),
    .cpu_ack (cpu_ack),
    .cpu_data(cpu_data),
    .waiting (waiting)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Tick phase from edges since reset; debounce from a window of the last
  // DBC synchronised samples; handshake tracked as busy/pressed flags.
  int         m_edges = 0;
  logic [9:0] m_sw1 = '0, m_sws = '0;
  logic       m_db = 1'b0;
  logic       hist [DBC];
  bit         m_busy = 0, m_pressed = 0, m_in_ack = 0;
  logic       m_en = 1'b0, m_ack = 1'b0, m_wait = 1'b0;
  logic [7:0] m_data = '0;

  task automatic model_reset();
    m_edges = 0; m_sw1 = '0; m_sws = '0; m_db = 1'b0;
    for (int i = 0; i < DBC; i++) hist[i] = 1'b0;
    m_busy = 0; m_pressed = 0; m_in_ack = 0;
    m_en = 1'b0; m_ack = 1'b0; m_wait = 1'b0; m_data = '0;
  endtask

  task automatic model_step();
    bit   tick, halt, all_differ;
    logic n_en, n_ack, n_wait;
    tick = ((m_edges % DIV) == DIV - 1);
    halt = 0;
`ifdef PICOMIPS_HALT_SWITCH_EN
    halt = m_sws[9];
`endif
    n_en = 1'b0; n_ack = 1'b0; n_wait = 1'b0;
    if (m_in_ack) begin
      m_in_ack = 0;
      n_en = tick && !halt;
    end else if (!m_busy) begin
      if (cpu_req) begin
        m_busy = 1; m_pressed = 0; n_wait = 1'b1;
      end else begin
        n_en = tick && !halt;
      end
    end else if (!cpu_req) begin
      m_busy = 0;
      n_en = tick && !halt;
    end else if (!m_pressed) begin
      n_wait = 1'b1;
      if (m_db) begin
        m_data = m_sws[7:0];
        m_pressed = 1;
      end
    end else if (!m_db) begin
      m_busy = 0; m_in_ack = 1; n_en = 1'b1; n_ack = 1'b1;
    end else begin
      n_wait = 1'b1;
    end
    m_en = n_en; m_ack = n_ack; m_wait = n_wait;
    // debounced bit flips once the last DBC samples all disagree with it
    for (int i = DBC - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = m_sws[8];
    all_differ = 1;
    for (int i = 0; i < DBC; i++) if (hist[i] == m_db) all_differ = 0;
    if (all_differ) m_db = m_sws[8];
    m_sws = m_sw1;
    m_sw1 = sw_raw;
    m_edges++;
  endtask

  always @(posedge clk or negedge nReset) begin
    if (!nReset) model_reset();
    else         model_step();
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("cyc_cpu_en", cpu_en, m_en);
    check("cyc_cpu_ack", cpu_ack, m_ack);
    check("cyc_waiting", waiting, m_wait);
    check("cyc_cpu_data", cpu_data, m_data);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  // Wait (bounded) for cpu_ack; optionally drop cpu_req as soon as it is seen.
  task automatic wait_ack(input string name, input bit drop_req);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc(1);
      if (cpu_ack) begin
        seen = 1;
        check({name, "_ack_en"}, cpu_en, 1);
        if (drop_req) cpu_req = 1'b0;
      end
    end
    check({name, "_ack_seen"}, seen, 1);
    $display("[TB] %s: ack=%0d data=0x%02h", name, seen, cpu_data);
  endtask

  initial begin
    int acks, ens;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, ens;
    bit ok;

    // Reset state
    cyc(2);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_cpu_data", cpu_data, 0);
    nReset = 1'b1;

    // Free run: pulses every 4th cycle after release, no ack
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      check($sformatf("freerun_en_%0d", k), cpu_en, (k % 4 == 0));
      check($sformatf("freerun_ack_%0d", k), cpu_ack, 0);
    end
    $display("[TB] free run: 20 cycles");

    // Handshake with 0xA5
    sw_raw[7:0] = 8'hA5;
    cyc(1);
    cpu_req = 1'b1;
    cyc(3);
    check("hs_waiting", waiting, 1);
    check("hs_en_stalled", cpu_en, 0);
    sw_raw[8] = 1'b1;
    cyc(10);
    check("hs_data", cpu_data, 8'hA5);
    sw_raw[8] = 1'b0;
    acks = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (cpu_ack) begin
        acks++;
        check("hs_ack_en", cpu_en, 1);
        cpu_req = 1'b0;
      end
    end
    check("hs_ack_count", acks, 1);
    check("hs_waiting_after", waiting, 0);
    $display("[TB] handshake: data=0x%02h acks=%0d", cpu_data, acks);

    // Bounce: SW[8] toggles every 2 cycles, never debounces high
    sw_raw[7:0] = 8'h5A;
    cpu_req = 1'b1;
    cyc(3);
    for (int i = 0; i < 6; i++) begin
      sw_raw[8] = ~sw_raw[8];
      cyc(2);
    end
    sw_raw[8] = 1'b0;
    cyc(6);
    check("bounce_data", cpu_data, 8'hA5);
    check("bounce_waiting", waiting, 1);
    cpu_req = 1'b0;
    cyc(2);
    check("bounce_abort_waiting", waiting, 0);
    $display("[TB] bounce: data=0x%02h", cpu_data);

    // Abort during WAIT_RELEASE
    sw_raw[7:0] = 8'h77;
    cpu_req = 1'b1;
    sw_raw[8] = 1'b1;
    cyc(8);
    check("abort_data", cpu_data, 8'h77);
    sw_raw[8] = 1'b0;
    cyc(2);
    cpu_req = 1'b0;
    acks = 0; ens = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (cpu_ack) acks++;
      if (cpu_en) ens++;
    end
    check("abort_no_ack", acks, 0);
    check("abort_en_resumes", ens, 3);
    check("abort_data_kept", cpu_data, 8'h77);
    $display("[TB] abort: acks=%0d en_pulses=%0d", acks, ens);

    // Request arriving on a tick cycle suppresses the pulse
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if ((m_edges % DIV) == DIV - 1) ok = 1;
      else cyc(1);
    end
    check("prio_tick_found", ok, 1);
    cpu_req = 1'b1;
    cyc(1);
    check("prio_no_en", cpu_en, 0);
    check("prio_waiting", waiting, 1);
    cpu_req = 1'b0;
    cyc(3);
    $display("[TB] priority: req on tick, en=%0d", cpu_en);

    // Complete handshake with 0x3C, stay requesting, then reset in WAIT_PRESS
    sw_raw[7:0] = 8'h3C;
    cpu_req = 1'b1;
    sw_raw[8] = 1'b1;
    cyc(8);
    sw_raw[8] = 1'b0;
    wait_ack("b2b", 1'b0);
    cyc(3);
    check("b2b_data", cpu_data, 8'h3C);
    check("b2b_rewait", waiting, 1);
    nReset = 1'b0;
    #1;
    check("arst_en", cpu_en, 0);
    check("arst_ack", cpu_ack, 0);
    check("arst_data", cpu_data, 0);
    check("arst_waiting", waiting, 0);
    cpu_req = 1'b0;
    sw_raw = '0;
    cyc(2);
    nReset = 1'b1;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (cpu_ack) acks++;
    end
    check("arst_no_spurious_ack", acks, 0);
    check("arst_idle", waiting, 0);
    $display("[TB] reset mid-handshake: acks=%0d", acks);

`ifdef PICOMIPS_HALT_SWITCH_EN
    // Halt: no free-run pulses, handshake still acknowledges once
    sw_raw[9] = 1'b1;
    cyc(3);
    sw_raw[7:0] = 8'hC3;
    cpu_req = 1'b1;
    sw_raw[8] = 1'b1;
    acks = 0; ens = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 6) sw_raw[8] = 1'b0;
      cyc(1);
      if (cpu_ack) begin
        acks++;
        cpu_req = 1'b0;
      end
      if (cpu_en && !cpu_ack) ens++;
    end
    check("halt_no_en", ens, 0);
    check("halt_ack_count", acks, 1);
    check("halt_data", cpu_data, 8'hC3);
    sw_raw[9] = 1'b0;
    cyc(3);
    $display("[TB] halt: acks=%0d stray_en=%0d", acks, ens);
`endif

    // Randomised traffic checked cycle-by-cycle against the model
    acks = 0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(9) == 0) sw_raw[8] = ~sw_raw[8];
      if ($urandom_range(15) == 0) cpu_req = ~cpu_req;
      if ($urandom_range(4) == 0) sw_raw[7:0] = 8'($urandom);
`ifdef PICOMIPS_HALT_SWITCH_EN
      if ($urandom_range(24) == 0) sw_raw[9] = ~sw_raw[9];
`endif
      cyc(1);
      if (cpu_ack) begin
        acks++;
        $display("[TB] random: ack %0d data=0x%02h", acks, cpu_data);
      end
    end

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
